// File: rtl/sa_sched.sv
// Round-robin two-requester front end driving a bit-serial adder (one full-adder slice + carry flop).
// Optional SA_SCHED_COUT_EN: registers the final carry into cout; otherwise cout is tied low.
module sa_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] out,
    output logic             cout
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_res, r_out;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_gnt;
    logic             r_carry, r_last, r_own, r_done_id;
    logic             w_start, w_win, w_sum, w_cy, w_last_bit;

    // Tie goes to whoever was not granted last; a lone requester always wins.
    assign w_win      = (req0 && req1) ? ~r_last : req1;
    assign w_start    = (r_state == IDLE) && (req0 || req1);
    assign w_sum      = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cy       = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_last_bit = (r_state == SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE:  if (req0 || req1) w_next = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (w_last_bit) w_next = DONE;
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_out     <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_carry   <= 1'b0;
            r_last    <= 1'b1;
            r_own     <= 1'b0;
            r_done_id <= 1'b0;
        end else begin
            r_gnt <= '0;
            if (w_start) begin
                r_a     <= w_win ? a1 : a0;
                r_b     <= w_win ? b1 : b0;
                r_res   <= '0;
                r_cnt   <= '0;
                r_carry <= 1'b0;
                r_gnt   <= w_win ? 2'b10 : 2'b01;
                r_last  <= w_win;
                r_own   <= w_win;
            end else if (r_state == SHIFT) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_carry <= w_cy;
                r_res   <= {w_sum, r_res[WIDTH-1:1]};
                r_cnt   <= r_cnt + CNT_W'(1);
                if (w_last_bit) begin
                    r_out     <= {w_sum, r_res[WIDTH-1:1]};
                    r_done_id <= r_own;
                end
            end
        end
    end

`ifdef SA_SCHED_COUT_EN
    logic r_cout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            r_cout <= 1'b0;
        else if (w_last_bit) r_cout <= w_cy;
    end

    assign cout = r_cout;
`else
    assign cout = 1'b0;
`endif

    assign gnt     = r_gnt;
    assign out     = r_out;
    assign done_id = r_done_id;
endmodule

// File: tb/tb_sa_sched.sv
// Scoreboard bench for sa_sched (WIDTH=4): expected sums queued at request time, checked on done.
module tb_sa_sched;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]   gnt;
    logic         busy, done, done_id, cout;
    logic [W-1:0] out;

    typedef struct {
        logic [W-1:0] s;
        logic         id;
        logic         c;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    sa_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
        .out(out), .cout(cout)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [W:0]  full;
        full = {1'b0, a} + {1'b0, b};
        e.s  = full[W-1:0];
        e.id = id;
`ifdef SA_SCHED_COUT_EN
        e.c  = full[W];
`else
        e.c  = 1'b0;
`endif
        return e;
    endfunction

    // Scoreboard consumer: every done pops one expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done out=%0d id=%0d (no result expected)", out, done_id);
            end else begin
                e = sb.pop_front();
                if (out !== e.s || done_id !== e.id || cout !== e.c) begin
                    bad++;
                    $display("FAIL result got out=%0d id=%0d cout=%0d want out=%0d id=%0d cout=%0d",
                             out, done_id, cout, e.s, e.id, e.c);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // One transaction: checks grant value, busy, and grant-to-done spacing.
    task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input bit chg);
        int n;
        @(posedge clk); #1;
        if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
        else    begin req0 = 1'b1; a0 = a; b0 = b; end
        sb.push_back(model(id, a, b));
        n = 0;
        do begin @(negedge clk); n++; end while (gnt == 2'b00 && n < 20);
        total++;
        if (gnt !== (id ? 2'b10 : 2'b01) || busy !== 1'b1) begin
            bad++;
            $display("FAIL grant got gnt=%b busy=%b want gnt=%b busy=1", gnt, busy, id ? 2'b10 : 2'b01);
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        if (chg) a0 = 4'd9;
        n = 0;
        do begin @(negedge clk); n++; end while (done !== 1'b1 && n < 20);
        total++;
        if (n != W) begin
            bad++;
            $display("FAIL done_latency got %0d cycles after gnt want %0d", n, W);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if ({gnt, busy, done, done_id, out, cout} !== '0) begin
            bad++;
            $display("FAIL reset_state got gnt=%b busy=%b done=%b id=%b out=%0d cout=%b want all 0",
                     gnt, busy, done, done_id, out, cout);
        end
    endtask

    task automatic test_basic();
        send(1'b0, 4'd1, 4'd2, 1'b0);
        send(1'b1, 4'd3, 4'd2, 1'b0);
        send(1'b0, 4'd0, 4'd1, 1'b0);
        send(1'b1, 4'd10, 4'd4, 1'b0);
    endtask

    task automatic test_overflow();
        send(1'b0, 4'd15, 4'd1, 1'b0);
        send(1'b1, 4'd12, 4'd9, 1'b0);
    endtask

    task automatic test_back_to_back();
        int cyc, last_g, last_d, ng, nd;
        logic [1:0] want;
        do_reset();
        a0 = 4'd4; b0 = 4'd5; a1 = 4'd7; b1 = 4'd6;
        for (int k = 0; k < 4; k++) sb.push_back(model(k[0], k[0] ? 4'd7 : 4'd4, k[0] ? 4'd6 : 4'd5));
        req0 = 1'b1; req1 = 1'b1;
        cyc = 0; last_g = -1; last_d = -1; ng = 0; nd = 0; want = 2'b01;
        while (nd < 4 && cyc < 60) begin
            @(negedge clk); cyc++;
            if (gnt != 2'b00) begin
                total++;
                if (gnt !== want || (last_g >= 0 && cyc - last_g != W + 2)) begin
                    bad++;
                    $display("FAIL tie_grant got gnt=%b gap=%0d want gnt=%b gap=%0d", gnt, cyc - last_g, want, W + 2);
                end
                want = ~want; last_g = cyc; ng++;
                if (ng == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
            if (done) begin
                if (last_d >= 0) begin
                    total++;
                    if (cyc - last_d != W + 2) begin
                        bad++;
                        $display("FAIL done_period got %0d want %0d", cyc - last_d, W + 2);
                    end
                end
                last_d = cyc; nd++;
            end
        end
        total++;
        if (nd != 4) begin
            bad++;
            $display("FAIL tie_count got %0d dones want 4", nd);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n, nd;
        @(posedge clk); #1;
        req0 = 1'b1; a0 = 4'd5; b0 = 4'd6;
        n = 0;
        do begin @(negedge clk); n++; end while (gnt == 2'b00 && n < 20);
        @(posedge clk); #1; req0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++;
        if ({gnt, busy, done, done_id, out, cout} !== '0) begin
            bad++;
            $display("FAIL mid_reset got gnt=%b busy=%b done=%b id=%b out=%0d cout=%b want all 0",
                     gnt, busy, done, done_id, out, cout);
        end
        @(negedge clk); #1 rst = 1'b1;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        total++;
        if (nd != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset got dones=%0d busy=%b want 0 0", nd, busy);
        end
        send(1'b1, 4'd6, 4'd7, 1'b0);
    endtask

    task automatic test_operand_change();
        send(1'b0, 4'd2, 4'd2, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_operand_change();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
